pt_enc_multi: RTL and testbench

Parametrised PT2262-style tri-state remote-control encoder that generalises the fixed 12-trit, one-frame encoder.
- Adds configurable trit count, an alpha-unit prescaler, multi-frame repeat and a graceful stop.
- Sits between the UART command decoder, which supplies address/data words, and the RF/OOK output pin.
- Produces one serial OOK waveform `q` plus busy/done status.

---
 rtl/pt_pkg.sv | 37 +++
 rtl/pt_prescaler.sv | 31 +++
 rtl/pt_enc_multi.sv | 141 ++++++++++++++
 tb/tb_pt_enc_multi.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pt_pkg.sv
// Shared encodings, slot timing and codebit waveform rule for the
// PT2262-style tri-state encoder.
package pt_pkg;

  localparam logic [1:0] TRIT_ZERO  = 2'b00;
  localparam logic [1:0] TRIT_ONE   = 2'b01;
  localparam logic [1:0] TRIT_FLOAT = 2'b10;
  localparam logic [1:0] TRIT_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CODE = 2'd1,
    SYNC = 2'd2
  } pt_state_e;

  localparam int CODE_LEN = 32;
  localparam int SYNC_LEN = 128;
  localparam int PW_SHORT = 4;
  localparam int PW_LONG  = 12;

  // Level of a codebit at alpha index 0..31; bit 4 selects the 16-alpha half.
  function automatic logic code_level(input logic [1:0] trit, input logic [4:0] alpha);
    logic short_hi;
    logic long_hi;
    logic lvl;
    short_hi = (alpha[3:0] < 4'(PW_SHORT));
    long_hi  = (alpha[3:0] < 4'(PW_LONG));
    case (trit)
      TRIT_ZERO:  lvl = short_hi;
      TRIT_ONE:   lvl = long_hi;
      TRIT_FLOAT: lvl = alpha[4] ? long_hi : short_hi;
      default:    lvl = 1'b0;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/pt_prescaler.sv
// Alpha-unit prescaler: one-cycle tick every DIV enabled clocks, restartable
// so the first alpha after a load is full length.
module pt_prescaler #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en || tick) cnt_d = '0;
    else                    cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pt_enc_multi.sv
// Parametrised tri-state OOK encoder: NTRITS codebits plus sync per frame,
// repeated up to reps times, with a sticky stop honoured at frame end.
module pt_enc_multi
  import pt_pkg::*;
#(
  parameter int NTRITS = 12,
  parameter int DIV    = 1,
  parameter int REP_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld,
  input  logic [2*NTRITS-1:0]   ad,
  input  logic [REP_W-1:0]      reps,
  input  logic                  stop,
  output logic                  q,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  done,
  output pt_state_e             dbg_state
);

  localparam int TW = (NTRITS > 1) ? $clog2(NTRITS) : 1;
  localparam logic [TW-1:0] LAST_TRIT = TW'(NTRITS - 1);

  pt_state_e            state_q, state_d;
  logic [2*NTRITS-1:0]  word_q, word_d;
  logic [REP_W-1:0]     frames_q, frames_d;
  logic [TW-1:0]        trit_q, trit_d;
  logic [6:0]           alpha_q, alpha_d;
  logic                 stop_q, stop_d;
  logic                 q_q, q_d;
  logic                 tick;
  logic                 accept;
  logic [1:0]           cur_trit;

  // ld/busy: ld is a request taken on any edge where busy is low; busy acts
  // as not-ready, so ld while busy (including the last frame clock) is dropped.
  assign busy      = (state_q != IDLE);
  assign accept    = (state_q == IDLE) && ld;
  assign q         = q_q;
  assign dbg_state = state_q;

  pt_prescaler #(.DIV(DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (busy),
    .clr  (accept),
    .tick (tick)
  );

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    frames_d   = frames_q;
    trit_d     = trit_q;
    alpha_d    = alpha_q;
    stop_d     = stop_q | (busy & stop);
    frame_done = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld) begin
          state_d  = CODE;
          word_d   = ad;
          frames_d = (reps == '0) ? REP_W'(1) : reps;
          trit_d   = '0;
          alpha_d  = '0;
          stop_d   = 1'b0;
        end
      end
      CODE: begin
        if (tick) begin
          if (alpha_q == 7'(CODE_LEN - 1)) begin
            alpha_d = '0;
            if (trit_q == LAST_TRIT) state_d = SYNC;
            else                     trit_d  = trit_q + TW'(1);
          end else begin
            alpha_d = alpha_q + 7'd1;
          end
        end
      end
      SYNC: begin
        if (tick) begin
          if (alpha_q == 7'(SYNC_LEN - 1)) begin
            frame_done = 1'b1;
            alpha_d    = '0;
            trit_d     = '0;
            // Last frame or stop pending: drop to idle, otherwise replay the word.
            if (frames_q == REP_W'(1) || stop_q) begin
              state_d = IDLE;
              done    = 1'b1;
              stop_d  = 1'b0;
            end else begin
              state_d  = CODE;
              frames_d = frames_q - REP_W'(1);
            end
          end else begin
            alpha_d = alpha_q + 7'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output level is looked up from the next slot position so q is registered
  // yet aligned with the state it belongs to.
  always_comb begin
    cur_trit = TRIT_ZERO;
    for (int i = 0; i < NTRITS; i++) begin
      if (trit_d == TW'(i)) cur_trit = word_d[2*(NTRITS-1-i) +: 2];
    end
    case (state_d)
      CODE:    q_d = code_level(cur_trit, alpha_d[4:0]);
      SYNC:    q_d = (alpha_d < 7'(PW_SHORT));
      default: q_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      word_q   <= '0;
      frames_q <= '0;
      trit_q   <= '0;
      alpha_q  <= '0;
      stop_q   <= 1'b0;
      q_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      frames_q <= frames_d;
      trit_q   <= trit_d;
      alpha_q  <= alpha_d;
      stop_q   <= stop_d;
      q_q      <= q_d;
    end
  end

endmodule

// File: tb/tb_pt_enc_multi.sv
// Bench for pt_enc_multi: a default instance and an NTRITS=4/DIV=3 instance,
// each checked every cycle against a cycle-offset waveform model.
module tb_pt_enc_multi;
  import pt_pkg::*;

  localparam int NA = 12, DA = 1, NB = 4, DB = 3, RW = 4;

  logic clk = 1'b0;
  logic rst_n;

  logic           ld_a = 1'b0, stop_a = 1'b0;
  logic [23:0]    ad_a = '0;
  logic [RW-1:0]  reps_a = '0;
  logic           q_a, busy_a, fd_a, done_a;
  pt_state_e      st_a;

  logic           ld_b = 1'b0, stop_b = 1'b0;
  logic [7:0]     ad_b = '0;
  logic [RW-1:0]  reps_b = '0;
  logic           q_b, busy_b, fd_b, done_b;
  pt_state_e      st_b;

  int errors = 0;
  int checks = 0;

  pt_enc_multi #(.NTRITS(NA), .DIV(DA), .REP_W(RW)) dut_a (
    .clk(clk), .rst(rst_n), .ld(ld_a), .ad(ad_a), .reps(reps_a), .stop(stop_a),
    .q(q_a), .busy(busy_a), .frame_done(fd_a), .done(done_a), .dbg_state(st_a));

  pt_enc_multi #(.NTRITS(NB), .DIV(DB), .REP_W(RW)) dut_b (
    .clk(clk), .rst(rst_n), .ld(ld_b), .ad(ad_b), .reps(reps_b), .stop(stop_b),
    .q(q_b), .busy(busy_b), .frame_done(fd_b), .done(done_b), .dbg_state(st_b));

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit          m_busy [2];
  int          m_t    [2];
  int          m_nfr  [2];
  logic [23:0] m_word [2];
  bit          m_stop [2];

  function automatic int flen(input int n, input int d);
    return d * (32 * n + 128);
  endfunction

  // Expected level at clock offset t (0 = first busy clock) of a transmission.
  function automatic bit exp_wave(input logic [23:0] w, input int n, input int d, input int t);
    int u, tr, a, pos;
    logic [1:0] c;
    u = (t % flen(n, d)) / d;
    if (u >= 32 * n) return (u - 32 * n) < 4;
    tr  = u / 32;
    a   = u % 32;
    pos = a % 16;
    c   = 2'((w >> (2 * (n - 1 - tr))) & 24'h3);
    case (c)
      2'b00:   return pos < 4;
      2'b01:   return pos < 12;
      2'b10:   return (a < 16) ? (pos < 4) : (pos < 12);
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_step(input int i, input bit ld, input logic [23:0] ad, input int reps,
                            input bit st, input int n, input int d);
    bit end_frame;
    if (m_busy[i]) begin
      end_frame = (m_t[i] % flen(n, d)) == flen(n, d) - 1;
      if (end_frame && (m_nfr[i] == 1 || m_stop[i])) begin
        m_busy[i] = 1'b0;
        m_stop[i] = 1'b0;
      end else begin
        if (end_frame) m_nfr[i] = m_nfr[i] - 1;
        m_t[i]    = m_t[i] + 1;
        m_stop[i] = m_stop[i] | st;
      end
    end else if (ld) begin
      m_busy[i] = 1'b1;
      m_t[i]    = 0;
      m_nfr[i]  = (reps == 0) ? 1 : reps;
      m_word[i] = ad;
      m_stop[i] = 1'b0;
    end
  endtask

  task automatic cmp1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%b expected=%b", nm, $time, act, exp);
    end
  endtask

  task automatic cmp_out(input int i, input logic q, input logic bz, input logic fd,
                         input logic dn, input int n, input int d);
    bit e_q, e_fd, e_dn;
    e_q  = m_busy[i] ? exp_wave(m_word[i], n, d, m_t[i]) : 1'b0;
    e_fd = m_busy[i] && ((m_t[i] % flen(n, d)) == flen(n, d) - 1);
    e_dn = e_fd && (m_nfr[i] == 1 || m_stop[i]);
    cmp1(i == 0 ? "q_a" : "q_b", q, e_q);
    cmp1(i == 0 ? "busy_a" : "busy_b", bz, m_busy[i]);
    cmp1(i == 0 ? "frame_done_a" : "frame_done_b", fd, e_fd);
    cmp1(i == 0 ? "done_a" : "done_b", dn, e_dn);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0d expected=%0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- event log for literal checks ----------------
  int cyc_a = 0, cyc_b = 0;
  int done_cnt_a = 0, done_cyc_a = 0, done_cnt_b = 0, done_cyc_b = 0;
  int fd_b_q[$];
  int runs_w[$], runs_s[$];
  int run_s = 0, run_l = 0;
  bit q_prev = 1'b0;

  // Inputs change at negedge+1, so values seen here are those the last posedge used.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] = 1'b0;
        m_stop[i] = 1'b0;
      end
    end else begin
      model_step(0, ld_a, ad_a, int'(reps_a), stop_a, NA, DA);
      model_step(1, ld_b, {16'h0, ad_b}, int'(reps_b), stop_b, NB, DB);
    end
    cmp_out(0, q_a, busy_a, fd_a, done_a, NA, DA);
    cmp_out(1, q_b, busy_b, fd_b, done_b, NB, DB);

    cyc_a = busy_a ? cyc_a + 1 : 0;
    cyc_b = busy_b ? cyc_b + 1 : 0;
    if (done_a) begin done_cnt_a++; done_cyc_a = cyc_a; end
    if (done_b) begin done_cnt_b++; done_cyc_b = cyc_b; end
    if (fd_b) fd_b_q.push_back(cyc_b);
    if (q_a) begin
      if (!q_prev) begin run_s = cyc_a; run_l = 0; end
      run_l++;
    end else if (q_prev) begin
      runs_w.push_back(run_l);
      runs_s.push_back(run_s);
    end
    q_prev = q_a;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    done_cnt_a = 0; done_cyc_a = 0; done_cnt_b = 0; done_cyc_b = 0;
    fd_b_q.delete();
    runs_w.delete();
    runs_s.delete();
  endtask

  task automatic start_a(input logic [23:0] ad, input int reps);
    ld_a = 1'b1; ad_a = ad; reps_a = RW'(reps);
    tick();
    ld_a = 1'b0; ad_a = 24'($urandom); reps_a = RW'($urandom);
  endtask

  task automatic start_b(input logic [7:0] ad, input int reps);
    ld_b = 1'b1; ad_b = ad; reps_b = RW'(reps);
    tick();
    ld_b = 1'b0; ad_b = 8'($urandom); reps_b = RW'($urandom);
  endtask

  task automatic wait_idle_a(input int bound);
    int n = 0;
    while (busy_a && n < bound) begin tick(); n++; end
    chk("idle_a_timeout", int'(busy_a), 0);
  endtask

  task automatic wait_idle_b(input int bound);
    int n = 0;
    while (busy_b && n < bound) begin tick(); n++; end
    chk("idle_b_timeout", int'(busy_b), 0);
  endtask

  task automatic wait_cyc_a(input int c);
    int n = 0;
    while (cyc_a != c && n < 5000) begin tick(); n++; end
    chk("cyc_a_reach", cyc_a, c);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    chk("reset_q", int'(q_a), 0);
    chk("reset_busy", int'(busy_a), 0);
    chk("reset_done", int'(done_a), 0);
    chk("reset_fd", int'(fd_a), 0);
    rst_n = 1'b1;
    tick();

    // All-zero word, one frame.
    clear_log();
    start_a(24'h000000, 1);
    wait_idle_a(600);
    chk("t1_done_cnt", done_cnt_a, 1);
    chk("t1_done_cyc", done_cyc_a, 512);
    chk("t1_run0_start", runs_s[0], 1);
    chk("t1_run0_width", runs_w[0], 4);
    chk("t1_run1_start", runs_s[1], 17);
    chk("t1_sync_start", runs_s[$], 385);
    chk("t1_sync_width", runs_w[$], 4);
    tick();

    // Word {one, float, reserved, zero, ...}.
    clear_log();
    start_a(24'h6C0000, 1);
    wait_idle_a(600);
    chk("t2_w0", runs_w[0], 12); chk("t2_s0", runs_s[0], 1);
    chk("t2_w1", runs_w[1], 12); chk("t2_s1", runs_s[1], 17);
    chk("t2_w2", runs_w[2], 4);  chk("t2_s2", runs_s[2], 33);
    chk("t2_w3", runs_w[3], 12); chk("t2_s3", runs_s[3], 49);
    chk("t2_w4", runs_w[4], 4);  chk("t2_s4", runs_s[4], 97);
    chk("t2_w5", runs_w[5], 4);  chk("t2_s5", runs_s[5], 113);
    tick();

    // NTRITS=4, DIV=3, three frames back to back.
    clear_log();
    start_b(8'($urandom), 3);
    wait_idle_b(2500);
    chk("t3_fd_cnt", fd_b_q.size(), 3);
    chk("t3_fd0", fd_b_q[0], 768);
    chk("t3_fd1", fd_b_q[1], 1536);
    chk("t3_fd2", fd_b_q[2], 2304);
    chk("t3_done_cnt", done_cnt_b, 1);
    chk("t3_done_cyc", done_cyc_b, 2304);
    tick();

    // Stop during first of five frames, then reload in the first idle cycle.
    clear_log();
    start_a(24'($urandom), 5);
    wait_cyc_a(100);
    stop_a = 1'b1;
    tick();
    stop_a = 1'b0;
    wait_idle_a(3000);
    chk("t4_done_cnt", done_cnt_a, 1);
    chk("t4_done_cyc", done_cyc_a, 512);
    ld_a = 1'b1; ad_a = 24'($urandom); reps_a = 1;
    tick();
    chk("t4_reload_busy", int'(busy_a), 1);
    ld_a = 1'b0;
    wait_idle_a(600);
    chk("t4_done_cnt2", done_cnt_a, 2);
    tick();

    // ld while busy (clock 50, clocks 511-512) ignored; held ld starts after one idle cycle.
    clear_log();
    start_a(24'($urandom), 1);
    wait_cyc_a(50);
    ld_a = 1'b1; ad_a = 24'($urandom);
    tick();
    ld_a = 1'b0;
    wait_cyc_a(511);
    ld_a = 1'b1; ad_a = 24'hA5965A; reps_a = 1;
    tick();
    chk("t5_done_at_512", int'(done_a), 1);
    tick();
    chk("t5_gap_idle", int'(busy_a), 0);
    tick();
    chk("t5_restart", int'(busy_a), 1);
    ld_a = 1'b0;
    wait_idle_a(600);
    chk("t5_done_cnt", done_cnt_a, 2);
    tick();

    // Asynchronous reset in the middle of a high pulse.
    clear_log();
    start_a(24'h555555, 1);
    wait_cyc_a(200);
    chk("t6_q_high_before", int'(q_a), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async_q", int'(q_a), 0);
    chk("t6_async_busy", int'(busy_a), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_no_done", done_cnt_a, 0);
    start_a(24'($urandom), 1);
    wait_idle_a(600);
    chk("t6_after_done_cyc", done_cyc_a, 512);
    tick();

    // Randomised transactions with stray ld and stop pulses.
    for (int k = 0; k < 6; k++) begin
      start_a(24'($urandom), $urandom_range(0, 2));
      for (int n = 0; n < 3000 && busy_a; n++) begin
        stop_a = ($urandom_range(0, 299) == 0);
        ld_a   = ($urandom_range(0, 99) == 0);
        ad_a   = 24'($urandom);
        tick();
      end
      stop_a = 1'b0; ld_a = 1'b0;
      chk("rand_a_timeout", int'(busy_a), 0);
      repeat ($urandom_range(0, 3)) tick();
    end
    for (int k = 0; k < 4; k++) begin
      start_b(8'($urandom), $urandom_range(0, 3));
      for (int n = 0; n < 5000 && busy_b; n++) begin
        stop_b = ($urandom_range(0, 999) == 0);
        ld_b   = ($urandom_range(0, 99) == 0);
        ad_b   = 8'($urandom);
        tick();
      end
      stop_b = 1'b0; ld_b = 1'b0;
      chk("rand_b_timeout", int'(busy_b), 0);
      repeat ($urandom_range(0, 3)) tick();
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
